traveler_cmd_decoder: RTL

Receiving end of the traveler operation link. Samples the 8-bit operation word that the button encoder drives. It filters glitches, decodes the one-hot operation field into a 3-bit opcode, and emits exactly one command per button press. Commands are queued in a small FIFO and drained by the machine/game logic over a valid/ready handshake. Sits between the traveler input encoder and the machine interaction logic.

---
 rtl/traveler_cmd_decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/traveler_cmd_decoder.sv
// traveler_cmd_decoder: debounces the traveler operation word and queues one opcode per press
//
// Ports:
//   clk        system clock, everything on posedge
//   rst_n      asynchronous active-low reset
//   data_in    [1:0] channel (2'b10 = operation), [6:2] one-hot op, [7] ignored
//   cmd_ready  consumer takes the head command this cycle
//   clr_err    clears bad_word and overflow on the next edge
//   cmd_valid  command FIFO non-empty
//   cmd_op     head opcode: 1 move, 2 throw, 3 interact, 4 get, 5 put
//   err_pulse  one-cycle pulse when a stable malformed word is seen while armed
//   bad_word   sticky malformed-word flag
//   overflow   sticky dropped-command flag
//   cmd_count  number of commands pushed, wraps at 256
module traveler_cmd_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       cmd_ready,
    input  logic       clr_err,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic       err_pulse,
    output logic       bad_word,
    output logic       overflow,
    output logic [7:0] cmd_count
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {WAIT_RELEASE, ARMED} state_t;

    logic [7:0]    data_q;
    logic [SW-1:0] stab_q, stab_d;
    state_t        state_q;
    logic          err_pulse_q, bad_word_q, overflow_q;
    logic [7:0]    cmd_count_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_bit7;

    logic [4:0] op;
    logic       stable, chan_ok, is_idle, is_onehot, act, push, pop, full, push_ok, drop;
    logic [2:0] opcode;

    assign unused_bit7 = data_q[7];

    // Restart at 1 when the incoming capture differs: that edge is the first sample of the new word.
    assign stable = stab_q == SW'(STABLE_CYCLES);
    assign stab_d = (data_in[6:0] != data_q[6:0]) ? SW'(1) : (stable ? stab_q : stab_q + SW'(1));

    assign op        = data_q[6:2];
    assign chan_ok   = data_q[1:0] == 2'b10;
    assign is_idle   = op == 5'd0;
    assign is_onehot = !is_idle && ((op & (op - 5'd1)) == 5'd0);
    assign opcode    = op[3] ? 3'd1 : op[4] ? 3'd2 : op[2] ? 3'd3 : op[0] ? 3'd4 : 3'd5;

    // Foreign-channel words never reach the FSM, so act already excludes them.
    assign act     = state_q == ARMED && stable && chan_ok;
    assign push    = act && is_onehot;
    assign pop     = cmd_valid && cmd_ready;
    assign full    = cnt_q == CW'(DEPTH);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            stab_q <= '0;
        end else begin
            data_q <= data_in;
            stab_q <= stab_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_RELEASE;
            err_pulse_q <= 1'b0;
            bad_word_q  <= 1'b0;
            overflow_q  <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            err_pulse_q <= act && !is_idle && !is_onehot && state_q == ARMED;
            bad_word_q  <= (bad_word_q && !clr_err) || (act && !is_idle && !is_onehot);
            overflow_q  <= (overflow_q && !clr_err) || drop;
            cmd_count_q <= cmd_count_q + 8'(push_ok);
            case (state_q)
                WAIT_RELEASE: if (stable && chan_ok && is_idle) state_q <= ARMED;
                ARMED:        if (act && !is_idle) state_q <= WAIT_RELEASE;
                default:      state_q <= WAIT_RELEASE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_ok ? wr_q + AW'(1) : wr_q;
            rd_q  <= pop ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_d;
        end
    end

    // When full with a simultaneous pop, wr_q == rd_q: the head is read before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= opcode;
    end

    assign cmd_valid = cnt_q != '0;
    assign cmd_op    = cmd_valid ? mem_q[rd_q] : 3'd0;
    assign err_pulse = err_pulse_q;
    assign bad_word  = bad_word_q;
    assign overflow  = overflow_q;
    assign cmd_count = cmd_count_q;
endmodule
